store_rmw_unit: RTL and testbench
=================================

Name: store_rmw_unit

Overview:
- Store-side counterpart of the load path's immediate/data widening: narrows a 32-bit register value into a byte or halfword and writes it into word-only data memory.
- Data memory has no byte enables, so SB/SH run a read-modify-write sequence; SW writes directly.
- Sits between the datapath's MEM stage and data memory. Stalls the pipeline through req_ready while busy.

Parameters:
ADDR_W, 32, byte-address width of req_addr and mem_addr.
RD_LAT, 1, data-memory read latency in cycles; mem_rd_data is valid RD_LAT cycles after mem_rd_en. The supported value is 1.

Ports:
clk  in  1  system clock, rising edge
rstb  in  1  asynchronous active-low reset
req_valid  in  1  store request from MEM stage
req_ready  out  1  unit idle; request accepted when req_valid & req_ready
req_addr  in  ADDR_W  byte address
req_data  in  32  register rt value; low bits used for SB/SH
req_size  in  2  store size: 00 byte, 01 half, 10 word, 11 illegal
mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0
mem_rd_en  out  1  one-cycle read strobe
mem_rd_data  in  32  read data
mem_wr_en  out  1  one-cycle write strobe
mem_wr_data  out  32  merged word
done  out  1  one-cycle pulse, store complete
err  out  1  one-cycle pulse, misaligned or illegal request dropped

Behaviour:
- Reset (rstb low, asynchronous): state IDLE; all outputs 0 except req_ready=1.
  - Reset mid-sequence abandons the store; no mem_wr_en is issued afterwards.
- All outputs are registered; decoding depends only on state.
- Byte order is big-endian (MIPS):
  - byte offset k = addr[1:0] occupies bits [31-8k : 24-8k];
  - half offset 0 occupies [31:16], offset 2 occupies [15:0];
  - SB uses req_data[7:0]; SH uses req_data[15:0].
- States: IDLE, RD_REQ, RD_WAIT, WRITE, ERR.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, data, size and offset.
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
  - Word -> WRITE with mem_wr_data=req_data.
  - Byte or half -> RD_REQ.
- RD_REQ: mem_rd_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}; -> RD_WAIT.
- RD_WAIT: capture mem_rd_data and replace the selected lane with the store data, leaving other lanes untouched; -> WRITE.
- WRITE: mem_wr_en=1, mem_addr aligned, done=1 in the same cycle; -> IDLE.
- ERR: err=1 for one cycle, no memory strobes; -> IDLE.
- Latency, counted from the accept edge (cycle 0):
  - word: write and done in cycle 1;
  - byte/half: read in cycle 1, write and done in cycle 3;
  - error: err in cycle 1.
- req_ready=0 in every non-IDLE state.
  - Requests presented while busy are ignored and not queued; the MEM stage must hold req_valid.
- A request presented on the same cycle as WRITE/ERR is not accepted.
  - It is accepted in the next IDLE cycle, giving back-to-back throughput of one store per 2 (word) or 4 (byte/half) cycles.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- mem_wr_data holds its last value when mem_wr_en=0.

Decomposition:
- Shared defines include, alongside the existing instruction field ranges:
  - store size codes (STORE_SIZE_BYTE/HALF/WORD);
  - state encodings;
  - a byte-lane index macro.
- One natural sub-module: store_lane_merge, a combinational block taking old word, store data, size and offset, and producing the merged word. It is reused by the bench as a reference model.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF -> cycle 1: mem_wr_en=1, mem_addr=0x100, mem_wr_data=0xDEADBEEF, done=1; mem_rd_en never asserted.
- SB addr 0x103, data 0x000000AB, mem returns 0x11223344 -> mem_rd_en cycle 1 at 0x100; cycle 3 mem_wr_data=0x112233AB, done=1.
- SH addr 0x202, data 0xFFFFCAFE, mem returns 0x55667788 -> write 0x5566CAFE at 0x200; then SH addr 0x200 with the same return value writes 0xCAFE7788.
- Misaligned: SH addr 0x101, then SW addr 0x102, then size 11 -> err pulse each, zero mem strobes, req_ready back high after 2 cycles.
- Back-to-back: req_valid held high for SB 0x0, SB 0x1, SB 0x2, SB 0x3 with data 0xA1..0xA4 against a modelled memory starting at 0 -> final word 0xA1A2A3A4; exactly 4 writes; requests are accepted only in IDLE.
- Reset mid-op: rstb low during RD_WAIT of an SB -> outputs immediately zero, req_ready=1, no mem_wr_en; the next SW after release completes normally.

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write unit.
//   - store size codes carried on req_size
//   - FSM state encoding
//   - big-endian lane position helpers used by the lane merge
package store_rmw_unit_pkg;

  localparam logic [1:0] STORE_SIZE_BYTE = 2'b00;
  localparam logic [1:0] STORE_SIZE_HALF = 2'b01;
  localparam logic [1:0] STORE_SIZE_WORD = 2'b10;
  localparam logic [1:0] STORE_SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  // Big-endian: byte offset k lives at bits [31-8k : 24-8k], so its LSB is
  // 24-8k, which is simply 8*(~k).
  function automatic logic [4:0] byte_lane_lsb(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Half at offset 0 is the upper half, offset 2 the lower half.
  function automatic logic [4:0] half_lane_lsb(input logic off_hi);
    return off_hi ? 5'd0 : 5'd16;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores.
//   old_word_i   : word read back from data memory
//   store_data_i : register value; [7:0] for byte, [15:0] for half, all for word
//   size_i       : store size code
//   offset_i     : byte offset within the word (big-endian lane numbering)
//   merged_o     : old word with the selected lane replaced
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      STORE_SIZE_BYTE: merged_o[byte_lane_lsb(offset_i) +: 8]  = store_data_i[7:0];
      STORE_SIZE_HALF: merged_o[half_lane_lsb(offset_i[1]) +: 16] = store_data_i[15:0];
      STORE_SIZE_WORD: merged_o = store_data_i;
      default:         merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for word-only data memory. SW writes directly; SB/SH read the
// target word, merge the new lane and write it back. Misaligned or illegal
// requests are dropped with an err pulse.
//   clk, rstb                : clock, asynchronous active-low reset
//   req_valid/ready          : request handshake from MEM stage (ready = idle)
//   req_addr/data/size       : byte address, register value, size code
//   mem_addr                 : word-aligned memory address
//   mem_rd_en / mem_rd_data  : read strobe and returned word
//   mem_wr_en / mem_wr_data  : write strobe and merged word
//   done / err               : single-cycle completion / drop pulses
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic              req_ready_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_en_q;
  logic              mem_wr_en_q;
  logic [31:0]       mem_wr_data_q;
  logic              done_q;
  logic              err_q;
  logic [3:0]        wait_q;

  // Request payload, captured on accept; only meaningful while busy.
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;

  logic              accept;
  logic              req_bad;
  logic [31:0]       merged;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_bad = (req_size == STORE_SIZE_ILL) ||
                   ((req_size == STORE_SIZE_HALF) && req_addr[0]) ||
                   ((req_size == STORE_SIZE_WORD) && (req_addr[1:0] != 2'b00));

  store_lane_merge u_merge (
    .old_word_i   (mem_rd_data),
    .store_data_i (data_q),
    .size_i       (size_q),
    .offset_i     (off_q),
    .merged_o     (merged)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= req_data;
      size_q <= req_size;
      off_q  <= req_addr[1:0];
    end
  end

  // Outputs are registered: each transition sets the outputs of the state
  // being entered, and strobes default low so they last exactly one cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      mem_addr_q    <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wait_q        <= '0;
    end else begin
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (req_bad) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_size == STORE_SIZE_WORD) begin
                state_q       <= ST_WRITE;
                mem_wr_en_q   <= 1'b1;
                mem_wr_data_q <= req_data;
                done_q        <= 1'b1;
              end else begin
                state_q     <= ST_RD_REQ;
                mem_rd_en_q <= 1'b1;
              end
            end
          end
        end
        ST_RD_REQ: begin
          state_q <= ST_RD_WAIT;
          wait_q  <= 4'(RD_LAT - 1);
        end
        ST_RD_WAIT: begin
          // Read data is valid RD_LAT cycles after the strobe.
          if (wait_q == 4'd0) begin
            state_q       <= ST_WRITE;
            mem_wr_en_q   <= 1'b1;
            mem_wr_data_q <= merged;
            done_q        <= 1'b1;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_WRITE, ST_ERR: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;
  import store_rmw_unit_pkg::*;

  logic        clk;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  store_rmw_unit #(.ADDR_W(32), .RD_LAT(1)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_size    (req_size),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .done        (done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: one-cycle read latency, word-indexed.
  logic [31:0] mem [0:255];
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr[9:2]];
      rd_cnt = rd_cnt + 1;
    end
    if (mem_wr_en) begin
      mem[mem_addr[9:2]] = mem_wr_data;
      wr_cnt = wr_cnt + 1;
    end
    if (mem_rd_en && mem_wr_en) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] init;    // memory word before the store
    int          rd_cyc;  // 0 = no read expected
    int          wr_cyc;  // 0 = no write expected
    int          err_cyc; // 0 = no err expected
    int          rdy_cyc; // first cycle req_ready is back high
    logic [31:0] maddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [11];

  // Called at a negedge with the DUT idle; issues one request and watches
  // cycles 1..6 after the accept edge.
  task automatic run_vec(input int idx, input vec_t v);
    int rd_c, wr_c, dn_c, er_c, rd_y;
    logic [31:0] raddr, waddr, wdata;
    rd_c = 0; wr_c = 0; dn_c = 0; er_c = 0; rd_y = 0;
    raddr = '0; waddr = '0; wdata = '0;
    mem[v.addr[9:2]] = v.init;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_rd_en && rd_c == 0) begin rd_c = c; raddr = mem_addr; end
      if (mem_wr_en && wr_c == 0) begin wr_c = c; waddr = mem_addr; wdata = mem_wr_data; end
      if (done && dn_c == 0) dn_c = c;
      if (err && er_c == 0) er_c = c;
      if (req_ready && rd_y == 0) rd_y = c;
      if (c < 6) @(negedge clk);
    end
    chk($sformatf("v%0d_rd_cycle", idx), rd_c, v.rd_cyc);
    chk($sformatf("v%0d_wr_cycle", idx), wr_c, v.wr_cyc);
    chk($sformatf("v%0d_done_cycle", idx), dn_c, v.wr_cyc);
    chk($sformatf("v%0d_err_cycle", idx), er_c, v.err_cyc);
    chk($sformatf("v%0d_ready_cycle", idx), rd_y, v.rdy_cyc);
    if (v.rd_cyc != 0) chk($sformatf("v%0d_rd_addr", idx), raddr, v.maddr);
    if (v.wr_cyc != 0) begin
      chk($sformatf("v%0d_wr_addr", idx), waddr, v.maddr);
      chk($sformatf("v%0d_wr_data", idx), wdata, v.wdata);
      chk($sformatf("v%0d_mem_word", idx), mem[v.maddr[9:2]], v.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, n;
    int acc [4];
    logic [31:0] last_wdata;

    vecs[0]  = '{32'h100, 32'hDEADBEEF, STORE_SIZE_WORD, 32'h0,        0, 1, 0, 2, 32'h100, 32'hDEADBEEF};
    vecs[1]  = '{32'h103, 32'h000000AB, STORE_SIZE_BYTE, 32'h11223344, 1, 3, 0, 4, 32'h100, 32'h112233AB};
    vecs[2]  = '{32'h202, 32'hFFFFCAFE, STORE_SIZE_HALF, 32'h55667788, 1, 3, 0, 4, 32'h200, 32'h5566CAFE};
    vecs[3]  = '{32'h200, 32'hFFFFCAFE, STORE_SIZE_HALF, 32'h55667788, 1, 3, 0, 4, 32'h200, 32'hCAFE7788};
    vecs[4]  = '{32'h100, 32'h12345678, STORE_SIZE_BYTE, 32'hAABBCCDD, 1, 3, 0, 4, 32'h100, 32'h78BBCCDD};
    vecs[5]  = '{32'h041, 32'h0000005A, STORE_SIZE_BYTE, 32'h00000000, 1, 3, 0, 4, 32'h040, 32'h005A0000};
    vecs[6]  = '{32'h082, 32'h000000FF, STORE_SIZE_BYTE, 32'h11111111, 1, 3, 0, 4, 32'h080, 32'h1111FF11};
    vecs[7]  = '{32'h3FC, 32'h01020304, STORE_SIZE_WORD, 32'hFFFFFFFF, 0, 1, 0, 2, 32'h3FC, 32'h01020304};
    vecs[8]  = '{32'h101, 32'h00001234, STORE_SIZE_HALF, 32'h0,        0, 0, 1, 2, 32'h0,   32'h0};
    vecs[9]  = '{32'h102, 32'h00001234, STORE_SIZE_WORD, 32'h0,        0, 0, 1, 2, 32'h0,   32'h0};
    vecs[10] = '{32'h100, 32'h00001234, STORE_SIZE_ILL,  32'h0,        0, 0, 1, 2, 32'h0,   32'h0};

    rstb = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    mem_rd_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_mem_rd_en", {31'b0, mem_rd_en}, 32'h0);
    chk("rst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rstb = 1'b1;
    @(negedge clk);

    // Table-driven single stores
    for (int i = 0; i < 11; i++) begin
      rd0 = rd_cnt; wr0 = wr_cnt;
      if (i == 8) last_wdata = mem_wr_data;
      run_vec(i, vecs[i]);
      if (vecs[i].err_cyc != 0) begin
        chk($sformatf("v%0d_no_reads", i), rd_cnt - rd0, 0);
        chk($sformatf("v%0d_no_writes", i), wr_cnt - wr0, 0);
        chk($sformatf("v%0d_wdata_held", i), mem_wr_data, last_wdata);
      end
    end

    // Back-to-back SB with req_valid held high
    mem[0] = 32'h0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1;
    req_size  = STORE_SIZE_BYTE;
    for (int k = 0; k < 4; k++) begin
      req_addr = k;
      req_data = 32'hA1 + k;
      n = 0;
      while (!req_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (n >= 10) chk($sformatf("b2b_ready_timeout_%0d", k), 32'h0, 32'h1);
      acc[k] = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) @(negedge clk);
    chk("b2b_final_word", mem[0], 32'hA1A2A3A4);
    chk("b2b_write_count", wr_cnt - wr0, 4);
    chk("b2b_read_count", rd_cnt - rd0, 4);
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b_accept_spacing_%0d", k), acc[k] - acc[k-1], 4);

    // Reset during RD_WAIT of an SB
    mem[65] = 32'h99999999;
    wr0 = wr_cnt;
    req_addr = 32'h104; req_data = 32'h77; req_size = STORE_SIZE_BYTE; req_valid = 1'b1;
    @(negedge clk);            // cycle 1: RD_REQ
    req_valid = 1'b0;
    @(negedge clk);            // cycle 2: RD_WAIT
    rstb = 1'b0;
    #1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("midrst_mem_rd_en", {31'b0, mem_rd_en}, 32'h0);
    chk("midrst_mem_wr_en", {31'b0, mem_wr_en}, 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_wr_data", mem_wr_data, 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("midrst_no_write", wr_cnt - wr0, 0);
    chk("midrst_mem_untouched", mem[65], 32'h99999999);
    run_vec(100, vecs[0]);

    chk("no_rd_wr_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
